// File: rtl/latch_write_ctrl.sv
// Write controller for a bank of level-sensitive D latches.
// Each accepted word is presented on lat_d, then lat_en is driven through a
// SETUP -> OPEN -> HOLD window so d is stable around the transparent phase.
// At the end of HOLD the latch q is read back and any mismatch is flagged.
module latch_write_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  input  logic [WIDTH-1:0] lat_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      wr_count
);

  // Counter only ever holds a phase length minus one.
  localparam int MAXC  = (SETUP_CYC > PULSE_CYC) ?
                         ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                         ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_OPEN  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
    $error("latch_write_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             lat_en_q, lat_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      wr_count_q, wr_count_d;

  // Next-state logic: walk the write window, counting down each phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    lat_d_d    = lat_d_q;
    lat_en_d   = lat_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    wr_count_d = wr_count_q;
    case (state_q)
      S_IDLE: begin
        // in_ready is 0 only on the first cycle after reset, so no accept then.
        if (in_valid && in_ready_q) begin
          lat_d_d    = in_data;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = SETUP_LD;
          state_d    = S_SETUP;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          lat_en_d = 1'b1;
          cnt_d    = PULSE_LD;
          state_d  = S_OPEN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OPEN: begin
        if (cnt_q == '0) begin
          lat_en_d = 1'b0;
          cnt_d    = HOLD_LD;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // Latch is closed and d still stable: its q must now equal the word.
        if (cnt_q == '0) begin
          if (lat_q != lat_d_q) begin
            err_d = 1'b1;
          end
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          wr_count_d = wr_count_q + 16'd1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      lat_d_q    <= '0;
      lat_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      lat_d_q    <= lat_d_d;
      lat_en_q   <= lat_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign in_ready = in_ready_q;
  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wr_count = wr_count_q;

endmodule
